// File: rtl/sobel_edge.sv
// rtl/sobel_edge.sv - 3x3 Sobel edge detector on RGB444 line taps, 3-stage pipeline
module sobel_edge #(
   parameter int         WIDTH  = 640,
   parameter int         HEIGHT = 480,
   parameter logic [8:0] THRESH = 9'd100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] datain,
   input  logic [11:0] row1,
   input  logic [11:0] row2,
   input  logic        pix_valid,
   input  logic        frame_start,
   output logic [11:0] dataout,
   output logic        out_valid
);

   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

   // Gray weight R + 2G + B; 60 max, so 6 bits never overflow.
   function automatic logic [5:0] f_gray(input logic [11:0] p);
      return {2'b00, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b00, p[3:0]};
   endfunction

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [5:0]    r_win [3][3];
   logic          r_valid1, r_inner1;
   logic [8:0]    r_gx, r_gy;
   logic          r_valid2, r_inner2;

   logic [5:0]    w_g_top, w_g_mid, w_g_bot;
   logic [CW-1:0] w_tag_col;
   logic [RW-1:0] w_tag_row;
   logic          w_inner;
   logic [8:0]    w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
   logic [8:0]    w_abs_gx, w_abs_gy, w_mag;

   assign w_g_top = f_gray(row2);
   assign w_g_mid = f_gray(row1);
   assign w_g_bot = f_gray(datain);

   // frame_start re-anchors the incoming pixel to (0,0) regardless of the counters
   assign w_tag_col = frame_start ? '0 : r_col;
   assign w_tag_row = frame_start ? '0 : r_row;
   assign w_inner   = (int'(w_tag_col) >= 2) && (int'(w_tag_row) >= 2);

   // Column/row position of the next incoming pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (pix_valid) begin
         if (frame_start) begin
            r_col <= CW'(1);
            r_row <= '0;
         end else if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Stage 1: shift gray window one column on each accepted pixel, tag it
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               r_win[r][c] <= '0;
         r_valid1 <= 1'b0;
         r_inner1 <= 1'b0;
      end else begin
         r_valid1 <= pix_valid;
         r_inner1 <= pix_valid & w_inner;
         if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
               r_win[r][0] <= r_win[r][1];
               r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_g_top;
            r_win[1][2] <= w_g_mid;
            r_win[2][2] <= w_g_bot;
         end
      end
   end

   // Kernel sums are at most 240, so 9-bit modular differences are exact two's complement
   assign w_gx_pos = {3'b000, r_win[0][2]} + {2'b00, r_win[1][2], 1'b0} + {3'b000, r_win[2][2]};
   assign w_gx_neg = {3'b000, r_win[0][0]} + {2'b00, r_win[1][0], 1'b0} + {3'b000, r_win[2][0]};
   assign w_gy_pos = {3'b000, r_win[2][0]} + {2'b00, r_win[2][1], 1'b0} + {3'b000, r_win[2][2]};
   assign w_gy_neg = {3'b000, r_win[0][0]} + {2'b00, r_win[0][1], 1'b0} + {3'b000, r_win[0][2]};

   // Stage 2: signed horizontal and vertical gradients
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gx     <= '0;
         r_gy     <= '0;
         r_valid2 <= 1'b0;
         r_inner2 <= 1'b0;
      end else begin
         r_gx     <= w_gx_pos - w_gx_neg;
         r_gy     <= w_gy_pos - w_gy_neg;
         r_valid2 <= r_valid1;
         r_inner2 <= r_inner1;
      end
   end

   assign w_abs_gx = r_gx[8] ? (~r_gx + 9'd1) : r_gx;
   assign w_abs_gy = r_gy[8] ? (~r_gy + 9'd1) : r_gy;
   assign w_mag    = w_abs_gx + w_abs_gy;

   // Stage 3: L1 magnitude against threshold; border pixels are forced to no-edge
   always_ff @(posedge clk) begin
      if (reset) begin
         dataout   <= 12'h000;
         out_valid <= 1'b0;
      end else begin
         dataout   <= (r_inner2 && (w_mag > THRESH)) ? 12'hFFF : 12'h000;
         out_valid <= r_valid2;
      end
   end

endmodule
